instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Packs instruction fields into 16-bit instruction words, the inverse of the decode stage.
- Streams the words into instruction memory at consecutive addresses.
- Used by the program loader / self-test sequencer to build programs on-chip.
- Word layout:
  - cond [15:14]
  - opcode [13:10]
  - dest [9:7]
  - register format: src1 [6:4], src2 [3:1], bit 0 = 0
  - immediate/shift format: load_shift [6:0]

Parameters:
- ADDR_W, 8, instruction memory address width.
- WORD_W, 16, instruction word width (fixed; any other value is illegal).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE).
- base_addr  in  ADDR_W  first write address, sampled on start.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder can accept a tuple this cycle.
- in_last  in  1  tuple is the final word of the session.
- in_fmt  in  1  0 = register format, 1 = immediate/shift format.
- in_cond  in  2  condition code.
- in_opcode  in  4  opcode.
- in_dest  in  3  destination register.
- in_src1  in  3  source register 1 (register format only).
- in_src2  in  3  source register 2 (register format only).
- in_imm  in  7  load/shift immediate (immediate format only).
- imem_we  out  1  write strobe (acts as valid).
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  encoded word.
- busy  out  1  state is LOAD or DRAIN.
- done  out  1  level, high in DONE.
- err_ovf  out  1  level, address-space overflow, high in ERR.
- word_count  out  ADDR_W+1  number of words written this session.
- checksum  out  16  XOR of all words written (see Optional Feature).

Behaviour:
- **Reset:** state=IDLE. All of in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_ovf, word_count and checksum reset to 0. Reset mid-session drops any pending word and issues no write.
- **States:** IDLE, LOAD, DRAIN, DONE, ERR.
- **IDLE:**
  - start → LOAD.
  - Set addr_next=base_addr, word_count=0, checksum=0.
  - Clear done/err_ovf.
- **LOAD:**
  - in_ready = !imem_we || imem_ready.
  - An accept happens when in_valid && in_ready.
  - The word is encoded combinationally and registered into imem_wdata, with imem_addr=addr_next and imem_we=1 on the next cycle. Latency: 1 cycle from accept to strobe.
  - Register-format bit 0 is forced to 0. Unused fields of the non-selected format are ignored.
  - addr_next increments on each accept.
  - Accept with in_last=1 → DRAIN.
  - Accept when addr_next == 2^ADDR_W-1 and in_last=0 → that word is still written; state then moves to ERR after it drains.
- **Output hold:** while imem_we=1 and imem_ready=0, imem_addr and imem_wdata are held stable.
  - On imem_ready=1: word_count++ and checksum ^= imem_wdata.
  - imem_we drops unless a new accept occurs in the same cycle. Back-to-back accepts give 1 word/cycle.
- **DRAIN:**
  - in_ready=0.
  - When the last write completes (imem_we && imem_ready) → DONE, or → ERR if overflow is flagged.
- **DONE / ERR:**
  - in_ready=0, imem_we=0.
  - done=1 or err_ovf=1 respectively. word_count and checksum are held.
  - start → LOAD (new session; clears flags, count and checksum).
- **Ignored inputs:** start outside IDLE/DONE/ERR is ignored. in_valid outside LOAD is ignored (in_ready=0).
- **Wrap:** addresses never wrap silently. The overflow rule above guarantees this.

Optional Feature:
- Macro: INSTR_ENC_CHECKSUM_EN.
- **Defined:**
  - checksum accumulates the XOR of every word written.
  - On in_last, one extra trailer word equal to the final checksum is written at the next address. It is counted in word_count, and the DRAIN → DONE transition waits for it.
  - If the trailer would exceed the address space, the session goes to ERR.
- **Undefined:** checksum is tied to 0 and no trailer word is written.

Decomposition:
- Package instr_pkg holds:
  - field position constants: COND_HI/LO=15/14, OPC_HI/LO=13/10, DEST_HI/LO=9/7, SRC1_HI/LO=6/4, SRC2_HI/LO=3/1, IMM_HI/LO=6/0;
  - format enum FMT_REG=0, FMT_IMM=1;
  - condition code constants CC_AL=00, CC_EQ=01, CC_GE=10, CC_LT=11;
  - state enum enc_state_t.
- Submodule instr_pack: purely combinational field packer, shared with any future assembler logic. The FSM, output register and counters stay in instr_encoder.

Test Plan:
- **Register-format encode:** start, base_addr=0x10; tuple fmt=0, cond=01, opcode=0011, dest=5, src1=2, src2=7, last=1, imem_ready=1 → one write: addr 0x10, data 0x4EAE; then done=1, word_count=1.
- **Immediate-format encode:** fmt=1, cond=00, opcode=1000, dest=3, imm=0x55 → data 0x21D5. Nonzero src1/src2 on the same tuple do not change the data.
- **Backpressure:** 3 back-to-back tuples with imem_ready low for cycles 2–4 → imem_addr/imem_wdata held stable, in_ready=0 while stalled. Writes land at base, base+1, base+2 in order; no loss or duplication.
- **Overflow:** ADDR_W=8, base_addr=0xFE, 3 tuples with last only on the third → writes at 0xFE and 0xFF; err_ovf=1, done=0, word_count=2; third tuple never accepted.
- **Reset mid-session:** rst asserted while imem_we=1 and imem_ready=0 → next cycle IDLE, imem_we=0, word_count=0, no further writes.
- **Checksum (INSTR_ENC_CHECKSUM_EN):** words 0x4EAE, 0x21D5 → trailer 0x6F7B written at base+2; word_count=3, checksum=0x6F7B.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: field positions, format and
// condition codes, and the load-sequencer state type.
package instr_pkg;

    localparam int COND_HI = 15;
    localparam int COND_LO = 14;
    localparam int OPC_HI  = 13;
    localparam int OPC_LO  = 10;
    localparam int DEST_HI = 9;
    localparam int DEST_LO = 7;
    localparam int SRC1_HI = 6;
    localparam int SRC1_LO = 4;
    localparam int SRC2_HI = 3;
    localparam int SRC2_LO = 1;
    localparam int IMM_HI  = 6;
    localparam int IMM_LO  = 0;

    typedef enum logic {
        FMT_REG = 1'b0,
        FMT_IMM = 1'b1
    } fmt_t;

    localparam logic [1:0] CC_AL = 2'b00;
    localparam logic [1:0] CC_EQ = 2'b01;
    localparam logic [1:0] CC_GE = 2'b10;
    localparam logic [1:0] CC_LT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer producing one 16-bit instruction word; kept
// separate so assembler-side logic can reuse the exact same layout.
module instr_pack
    import instr_pkg::*;
(
    input  logic        fmt,
    input  logic [1:0]  cond,
    input  logic [3:0]  opcode,
    input  logic [2:0]  dest,
    input  logic [2:0]  src1,
    input  logic [2:0]  src2,
    input  logic [6:0]  imm,
    output logic [15:0] word
);

    always_comb begin
        word = '0;
        word[COND_HI:COND_LO] = cond;
        word[OPC_HI:OPC_LO]   = opcode;
        word[DEST_HI:DEST_LO] = dest;
        if (fmt == FMT_IMM) begin
            word[IMM_HI:IMM_LO] = imm;
        end else begin
            word[SRC1_HI:SRC1_LO] = src1;
            word[SRC2_HI:SRC2_LO] = src2;
            word[0]               = 1'b0;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs field tuples into words and streams them into
// instruction memory. Optional trailer checksum word: INSTR_ENC_CHECKSUM_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// LOAD  | accepting tuples, one registered write slot toward memory
// DRAIN | last word (and optional trailer) still in flight
// DONE  | session completed; count and checksum held
// ERR   | address space exhausted before in_last; count and checksum held
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              in_fmt,
    input  logic [1:0]        in_cond,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_dest,
    input  logic [2:0]        in_src1,
    input  logic [2:0]        in_src2,
    input  logic [6:0]        in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [ADDR_W:0]   word_count,
    output logic [15:0]       checksum
);

`ifdef INSTR_ENC_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_next_q, addr_next_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [15:0]       csum_q, csum_d;
    logic              ovf_q, ovf_d;
    logic              trailer_q, trailer_d;

    logic [15:0] pack_word;
    logic        in_ready_c;
    logic        accept;
    logic        complete;
    logic        at_max;

    instr_pack u_pack (
        .fmt    (in_fmt),
        .cond   (in_cond),
        .opcode (in_opcode),
        .dest   (in_dest),
        .src1   (in_src1),
        .src2   (in_src2),
        .imm    (in_imm),
        .word   (pack_word)
    );

    always_comb begin
        state_d     = state_q;
        addr_next_d = addr_next_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        csum_d      = csum_q;
        ovf_d       = ovf_q;
        trailer_d   = trailer_q;

        complete   = we_q && imem_ready;
        in_ready_c = (state_q == ST_LOAD) && (!we_q || imem_ready);
        accept     = in_valid && in_ready_c;
        at_max     = (addr_next_q == ADDR_MAX);

        // The trailer itself never folds back into the running checksum.
        if (complete) begin
            we_d    = 1'b0;
            count_d = count_q + 1'b1;
            if (CSUM_EN && !trailer_q) begin
                csum_d = csum_q ^ wdata_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    addr_next_d = base_addr;
                    count_d     = '0;
                    csum_d      = '0;
                    ovf_d       = 1'b0;
                    trailer_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d        = 1'b1;
                    addr_d      = addr_next_q;
                    wdata_d     = pack_word;
                    addr_next_d = addr_next_q + 1'b1;
                    // Last address taken: no room for more data or a trailer.
                    if (at_max && (!in_last || CSUM_EN)) begin
                        ovf_d = 1'b1;
                    end
                    if (in_last || at_max) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (complete) begin
                    if (ovf_q) begin
                        state_d = ST_ERR;
                    end else if (CSUM_EN && !trailer_q) begin
                        we_d      = 1'b1;
                        addr_d    = addr_next_q;
                        wdata_d   = csum_q ^ wdata_q;
                        trailer_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_next_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            count_q     <= '0;
            csum_q      <= '0;
            ovf_q       <= 1'b0;
            trailer_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_next_q <= addr_next_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            ovf_q       <= ovf_d;
            trailer_q   <= trailer_d;
        end
    end

    assign in_ready   = in_ready_c;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign err_ovf    = (state_q == ST_ERR);
    assign word_count = count_q;
    assign checksum   = csum_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a session-level model predicts every memory
// write and the final status; a monitor checks writes, stalls and hold each cycle.
module tb_instr_encoder;

`ifdef INSTR_ENC_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic        in_fmt;
    logic [1:0]  in_cond;
    logic [3:0]  in_opcode;
    logic [2:0]  in_dest;
    logic [2:0]  in_src1;
    logic [2:0]  in_src2;
    logic [6:0]  in_imm;
    logic        imem_we;
    logic        imem_ready;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err_ovf;
    logic [8:0]  word_count;
    logic [15:0] checksum;

    instr_encoder #(.ADDR_W(8), .WORD_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_fmt     (in_fmt),
        .in_cond    (in_cond),
        .in_opcode  (in_opcode),
        .in_dest    (in_dest),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err_ovf    (err_ovf),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Tuple table for the current session
    logic       t_fmt  [8];
    logic [1:0] t_cond [8];
    logic [3:0] t_opc  [8];
    logic [2:0] t_dest [8];
    logic [2:0] t_s1   [8];
    logic [2:0] t_s2   [8];
    logic [6:0] t_imm  [8];

    task automatic set_tuple(input int i, input logic f, input logic [1:0] c, input logic [3:0] o,
                             input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                             input logic [6:0] im);
        t_fmt[i] = f; t_cond[i] = c; t_opc[i] = o; t_dest[i] = d;
        t_s1[i] = s1; t_s2[i] = s2; t_imm[i] = im;
    endtask

    function automatic logic [15:0] enc(input int i);
        int v;
        v = t_cond[i] * 16384 + t_opc[i] * 1024 + t_dest[i] * 128;
        if (t_fmt[i]) v = v + t_imm[i];
        else          v = v + t_s1[i] * 16 + t_s2[i] * 2;
        return v[15:0];
    endfunction

    // Expected writes as {addr, data}
    logic [23:0] exp_q[$];
    logic        first_pending = 1'b0;
    logic [7:0]  first_addr;
    logic [15:0] first_data;

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_addr;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_we", imem_we, 1'b1);
                chk("hold_addr", imem_addr, prev_addr);
                chk("hold_wdata", imem_wdata, prev_data);
            end
            if (imem_we && !imem_ready) chk("stall_in_ready", in_ready, 1'b0);
            if (imem_we && imem_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    chk("write_addr", imem_addr, e[23:16]);
                    chk("write_data", imem_wdata, e[15:0]);
                end
                if (first_pending) begin
                    first_addr    = imem_addr;
                    first_data    = imem_wdata;
                    first_pending = 1'b0;
                end
            end
            prev_stall = imem_we && !imem_ready;
            prev_addr  = imem_addr;
            prev_data  = imem_wdata;
        end
    end

    int          rel;
    logic [31:0] mask;

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        imem_ready = (rel < 32) ? !mask[rel] : 1'b1;
    endtask

    task automatic drive_tuple(input int i, input int n);
        in_fmt = t_fmt[i]; in_cond = t_cond[i]; in_opcode = t_opc[i]; in_dest = t_dest[i];
        in_src1 = t_s1[i]; in_src2 = t_s2[i]; in_imm = t_imm[i];
        in_last = (i == n - 1);
        in_valid = 1'b1;
    endtask

    task automatic run_session(input string tag, input int base, input int n, input logic [31:0] m);
        int          n_acc, exp_cnt, a, i, guard;
        logic [15:0] cs;
        logic        exp_err;
        n_acc = 0; exp_cnt = 0; cs = '0; exp_err = 1'b0;
        for (int k = 0; k < n; k++) begin
            a = base + k;
            exp_q.push_back({a[7:0], enc(k)});
            cs = cs ^ enc(k);
            exp_cnt++;
            n_acc++;
            if (a == 255 && k != n - 1) begin
                exp_err = 1'b1;
                break;
            end
        end
        if (CS && !exp_err) begin
            a = base + n;
            if (a > 255) exp_err = 1'b1;
            else begin
                exp_q.push_back({a[7:0], cs});
                exp_cnt++;
            end
        end
        if (!CS) cs = '0;

        mask = m;
        tick();
        start = 1'b1; base_addr = base[7:0]; rel = 0; imem_ready = !mask[0];
        first_pending = 1'b1;
        tick();
        start = 1'b0;
        i = 0; guard = 0;
        while (i < n_acc) begin
            drive_tuple(i, n);
            @(negedge clk);
            if (in_ready) i++;
            tick();
            guard++;
            if (guard > 100) begin
                chk({tag, "_accept_timeout"}, i, n_acc);
                break;
            end
        end
        in_valid = 1'b0;
        if (n_acc < n) begin
            drive_tuple(n_acc, n);
            repeat (3) begin
                @(negedge clk);
                chk({tag, "_refused_ready"}, in_ready, 1'b0);
                tick();
            end
            in_valid = 1'b0;
        end
        guard = 0;
        forever begin
            @(negedge clk);
            if (done || err_ovf) break;
            guard++;
            if (guard > 60) begin
                chk({tag, "_end_timeout"}, {done, err_ovf}, {!exp_err, exp_err});
                break;
            end
            tick();
        end
        chk({tag, "_done"}, done, !exp_err);
        chk({tag, "_err_ovf"}, err_ovf, exp_err);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_imem_we"}, imem_we, 1'b0);
        chk({tag, "_word_count"}, word_count, exp_cnt);
        chk({tag, "_checksum"}, checksum, cs);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] lit_cs;
    logic [8:0]  lit_cnt;

    initial begin
        rel = 0; mask = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_fmt = 1'b0; in_cond = '0; in_opcode = '0; in_dest = '0; in_src1 = '0; in_src2 = '0;
        in_imm = '0; imem_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_checksum", checksum, 0);

        // Register format
        set_tuple(0, 1'b0, 2'b01, 4'b0011, 3'd5, 3'd2, 3'd7, 7'h7F);
        chk("model_enc_reg", enc(0), 16'h4EAE);
        run_session("reg", 'h10, 1, 32'h0);
        chk("reg_first_addr", first_addr, 8'h10);
        chk("reg_first_data", first_data, 16'h4EAE);

        // Immediate format, src fields must be ignored
        set_tuple(0, 1'b1, 2'b00, 4'b1000, 3'd3, 3'd6, 3'd5, 7'h55);
        chk("model_enc_imm", enc(0), 16'h21D5);
        run_session("imm", 'h20, 1, 32'h0);
        chk("imm_first_data", first_data, 16'h21D5);

        // Backpressure on three back-to-back tuples
        set_tuple(0, 1'b0, 2'b11, 4'b0101, 3'd1, 3'd3, 3'd4, 7'h00);
        set_tuple(1, 1'b1, 2'b10, 4'b1111, 3'd7, 3'd0, 3'd0, 7'h2A);
        set_tuple(2, 1'b0, 2'b00, 4'b0001, 3'd0, 3'd7, 3'd1, 7'h00);
        run_session("bp", 'h30, 3, 32'h0000_001C);

        // Checksum pair
        set_tuple(0, 1'b0, 2'b01, 4'b0011, 3'd5, 3'd2, 3'd7, 7'h00);
        set_tuple(1, 1'b1, 2'b00, 4'b1000, 3'd3, 3'd1, 3'd1, 7'h55);
        run_session("cs", 'h50, 2, 32'h0000_0024);
`ifdef INSTR_ENC_CHECKSUM_EN
        lit_cs = 16'h6F7B; lit_cnt = 9'd3;
`else
        lit_cs = 16'h0000; lit_cnt = 9'd2;
`endif
        chk("cs_literal_checksum", checksum, lit_cs);
        chk("cs_literal_count", word_count, lit_cnt);

        // Overflow: third tuple must never be accepted
        set_tuple(0, 1'b0, 2'b00, 4'b0010, 3'd2, 3'd1, 3'd1, 7'h00);
        set_tuple(1, 1'b1, 2'b01, 4'b0100, 3'd4, 3'd0, 3'd0, 7'h11);
        set_tuple(2, 1'b1, 2'b10, 4'b0110, 3'd6, 3'd0, 3'd0, 7'h22);
        run_session("ovf", 'hFE, 3, 32'h0000_0008);
        chk("ovf_literal_err", err_ovf, 1'b1);
        chk("ovf_literal_count", word_count, 9'd2);

        // Last word lands exactly on the top address
        set_tuple(0, 1'b1, 2'b11, 4'b1010, 3'd2, 3'd0, 3'd0, 7'h3C);
        run_session("top", 'hFF, 1, 32'h0);

        // Reset while a write is stalled
        mask = 32'hFFFF_FFFF;
        set_tuple(0, 1'b0, 2'b01, 4'b0111, 3'd3, 3'd3, 3'd3, 7'h00);
        tick();
        start = 1'b1; base_addr = 8'h40; rel = 0; imem_ready = 1'b0;
        tick();
        start = 1'b0;
        drive_tuple(0, 2);
        @(negedge clk);
        chk("mid_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_we_pending", imem_we, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mask = '0;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("mid_imem_we", imem_we, 1'b0);
        chk("mid_word_count", word_count, 0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_in_ready", in_ready, 1'b0);
        repeat (5) tick();
        @(negedge clk);
        chk("mid_idle_busy", busy, 1'b0);
        chk("mid_idle_done", done, 1'b0);

        // Recovery session after the reset
        set_tuple(0, 1'b0, 2'b10, 4'b1100, 3'd6, 3'd5, 3'd4, 7'h00);
        set_tuple(1, 1'b1, 2'b01, 4'b0011, 3'd1, 3'd2, 3'd3, 7'h7E);
        run_session("recov", 'h80, 2, 32'h0000_0010);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
